// File: rtl/quadrature_decoder.sv
// Quadrature encoder decoder: synchronized, glitch-filtered A/B channels drive a wrapping up/down position counter.
// Optional index channel (zeroes the count on its filtered rising edge) is enabled by defining QDEC_INDEX_EN.
module quadrature_decoder #(
    parameter int WIDTH      = 16,
    parameter int FILTER_LEN = 3
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             a_i,
    input  logic             b_i,
`ifdef QDEC_INDEX_EN
    input  logic             idx_i,
`endif
    input  logic             load_en_i,
    input  logic [WIDTH-1:0] load_count_i,
    input  logic             err_clr_i,
    output logic [WIDTH-1:0] count_o,
    output logic             dir_o,
    output logic             step_o,
    output logic             err_o
);

`ifdef QDEC_INDEX_EN
    localparam int NCH = 3;
`else
    localparam int NCH = 2;
`endif
    localparam logic [3:0] FL_LAST = 4'(FILTER_LEN - 1);

    logic [NCH-1:0] raw;
    logic [NCH-1:0] filt;

`ifdef QDEC_INDEX_EN
    assign raw = {idx_i, a_i, b_i};
`else
    assign raw = {a_i, b_i};
`endif

    // Reset asserts immediately but releases only on a clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_n_int;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) rst_sync_q <= 2'b00;
        else         rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n_int = rst_sync_q[1];

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [1:0] sync_q;
            logic       filt_q;
            logic [3:0] cnt_q;

            always_ff @(posedge clk_i or negedge rst_n_int) begin
                if (!rst_n_int) begin
                    sync_q <= 2'b00;
                    filt_q <= 1'b0;
                    cnt_q  <= 4'd0;
                end else begin
                    sync_q <= {sync_q[0], raw[gi]};
                    if (sync_q[1] == filt_q) begin
                        cnt_q <= 4'd0;
                    end else if (cnt_q == FL_LAST) begin
                        filt_q <= sync_q[1];
                        cnt_q  <= 4'd0;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
            end
            assign filt[gi] = filt_q;
        end
    endgenerate

    function automatic logic [1:0] gray2bin(input logic [1:0] g);
        return {g[1], g[1] ^ g[0]};
    endfunction

    logic [WIDTH-1:0] count_q, count_d;
    logic [1:0]       ab_prev_q, ab_prev_d;
    logic             dir_q, dir_d;
    logic             step_q, step_d;
    logic             err_q, err_d;
    logic [1:0]       delta;
    logic             illegal;

    assign delta = gray2bin(filt[1:0]) - gray2bin(ab_prev_q);

`ifdef QDEC_INDEX_EN
    logic idx_prev_q;
    always_ff @(posedge clk_i or negedge rst_n_int) begin
        if (!rst_n_int) idx_prev_q <= 1'b0;
        else            idx_prev_q <= filt[2];
    end
`endif

    always_comb begin
        count_d   = count_q;
        dir_d     = dir_q;
        step_d    = 1'b0;
        ab_prev_d = ab_prev_q;
        illegal   = 1'b0;
        // A change arriving right after a step is held one cycle so step_o never pulses back to back.
        if (!step_q) begin
            ab_prev_d = filt[1:0];
            case (delta)
                2'd1: begin
                    count_d = count_q + 1'b1;
                    dir_d   = 1'b1;
                    step_d  = 1'b1;
                end
                2'd3: begin
                    count_d = count_q - 1'b1;
                    dir_d   = 1'b0;
                    step_d  = 1'b1;
                end
                2'd2:    illegal = 1'b1;
                default: ;
            endcase
        end
`ifdef QDEC_INDEX_EN
        if (filt[2] && !idx_prev_q) begin
            count_d = '0;
            dir_d   = dir_q;
            step_d  = 1'b0;
        end
`endif
        if (load_en_i) begin
            count_d = load_count_i;
            dir_d   = dir_q;
            step_d  = 1'b0;
        end
        err_d = illegal | (err_q & ~err_clr_i);
    end

    always_ff @(posedge clk_i or negedge rst_n_int) begin
        if (!rst_n_int) begin
            count_q   <= '0;
            ab_prev_q <= 2'b00;
            dir_q     <= 1'b1;
            step_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            ab_prev_q <= ab_prev_d;
            dir_q     <= dir_d;
            step_q    <= step_d;
            err_q     <= err_d;
        end
    end

    assign count_o = count_q;
    assign dir_o   = dir_q;
    assign step_o  = step_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Scoreboard bench: a 16-bit and a 4-bit decoder share stimulus; expected counts are queued per driven step.
module tb_quadrature_decoder;
    logic        clk = 1'b0;
    logic        rstn, a, b, idx, load_en, err_clr;
    logic [15:0] load_count;
    logic [15:0] count16;
    logic [3:0]  count4;
    logic        dir16, step16, err16, dir4, step4, err4;

    always #5 clk = ~clk;

    quadrature_decoder #(.WIDTH(16), .FILTER_LEN(3)) dut16 (
        .clk_i(clk), .rstn_i(rstn), .a_i(a), .b_i(b),
`ifdef QDEC_INDEX_EN
        .idx_i(idx),
`endif
        .load_en_i(load_en), .load_count_i(load_count), .err_clr_i(err_clr),
        .count_o(count16), .dir_o(dir16), .step_o(step16), .err_o(err16));

    quadrature_decoder #(.WIDTH(4), .FILTER_LEN(3)) dut4 (
        .clk_i(clk), .rstn_i(rstn), .a_i(a), .b_i(b),
`ifdef QDEC_INDEX_EN
        .idx_i(idx),
`endif
        .load_en_i(load_en), .load_count_i(load_count[3:0]), .err_clr_i(err_clr),
        .count_o(count4), .dir_o(dir4), .step_o(step4), .err_o(err4));

    int vec_cnt = 0;
    int miscmp  = 0;
    int steps_seen = 0;
    int model_cnt = 0;
    int phase = 0;
    bit model_dir = 1'b1;
    bit step_prev = 1'b0;

    typedef struct { int cnt; bit dir; } exp_t;
    exp_t sb[$];

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscmp++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_step(input bit up, input bit expect_step);
        phase = up ? ((phase + 1) & 3) : ((phase + 3) & 3);
        a = phase[1];
        b = phase[1] ^ phase[0];
        if (expect_step) begin
            model_cnt = up ? ((model_cnt + 1) & 32'hFFFF) : ((model_cnt + 32'hFFFF) & 32'hFFFF);
            model_dir = up;
            sb.push_back('{model_cnt, up});
        end
    endtask

    task automatic do_load(input logic [15:0] val);
        load_en = 1'b1;
        load_count = val;
        @(negedge clk);
        load_en = 1'b0;
        model_cnt = int'(val);
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (step16) begin
                exp_t e;
                chk_eq("step_b2b", {31'd0, step_prev}, 32'd0);
                chk_eq("step4_vs_step16", {31'd0, step4}, 32'd1);
                steps_seen++;
                if (sb.size() == 0) begin
                    chk_eq("unexp_step", {31'd0, step16}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    $display("txn %0d: count16=%0h count4=%0h dir=%0d", steps_seen, count16, count4, dir16);
                    chk_eq("count16", {16'd0, count16}, e.cnt & 32'hFFFF);
                    chk_eq("count4", {28'd0, count4}, e.cnt & 32'hF);
                    chk_eq("dir16", {31'd0, dir16}, {31'd0, e.dir});
                    chk_eq("dir4", {31'd0, dir4}, {31'd0, e.dir});
                end
            end
            step_prev = step16;
        end else begin
            step_prev = 1'b0;
        end
    end

    initial begin
        int n;
        int seen0;
        rstn = 1'b0; a = 1'b0; b = 1'b0; idx = 1'b0;
        load_en = 1'b0; load_count = 16'd0; err_clr = 1'b0;
        #22;
        chk_eq("rst_count", {16'd0, count16}, 32'd0);
        chk_eq("rst_dir", {31'd0, dir16}, 32'd1);
        chk_eq("rst_step", {31'd0, step16}, 32'd0);
        chk_eq("rst_err", {31'd0, err16}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (5) @(negedge clk);

        // 20 up steps; the first one also measures edge-to-count latency
        drive_step(1'b1, 1'b1);
        n = 21;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (step16) begin
                n = i;
                break;
            end
        end
        chk_eq("latency", n, 32'd6);
        repeat (4) @(negedge clk);
        for (int s = 1; s < 20; s++) begin
            drive_step(1'b1, 1'b1);
            repeat (10) @(negedge clk);
        end
        chk_eq("up20_count", {16'd0, count16}, 32'd20);
        chk_eq("up20_dir", {31'd0, dir16}, 32'd1);
        chk_eq("up20_err", {31'd0, err16}, 32'd0);
        chk_eq("up20_pulses", steps_seen, 32'd20);

        // wrap both ways
        do_load(16'd0);
        chk_eq("load0_count4", {28'd0, count4}, 32'd0);
        drive_step(1'b0, 1'b1);
        repeat (10) @(negedge clk);
        chk_eq("wrap_dn4", {28'd0, count4}, 32'd15);
        chk_eq("wrap_dn16", {16'd0, count16}, 32'hFFFF);
        chk_eq("wrap_dn_dir", {31'd0, dir4}, 32'd0);
        drive_step(1'b1, 1'b1);
        repeat (10) @(negedge clk);
        chk_eq("wrap_up4", {28'd0, count4}, 32'd0);

        // 2-cycle glitch on A must be filtered out
        seen0 = steps_seen;
        a = 1'b1;
        repeat (2) @(negedge clk);
        a = 1'b0;
        repeat (12) @(negedge clk);
        chk_eq("glitch_count", {16'd0, count16}, model_cnt);
        chk_eq("glitch_steps", steps_seen, seen0);

        // both channels together: illegal
        a = 1'b1; b = 1'b1; phase = 2;
        repeat (10) @(negedge clk);
        chk_eq("illegal_err", {31'd0, err16}, 32'd1);
        chk_eq("illegal_err4", {31'd0, err4}, 32'd1);
        chk_eq("illegal_count", {16'd0, count16}, model_cnt);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk_eq("err_clr", {31'd0, err16}, 32'd0);
        drive_step(1'b1, 1'b1);
        repeat (10) @(negedge clk);
        drive_step(1'b1, 1'b1);
        repeat (10) @(negedge clk);

        // load coincident with a step: load wins, no pulse
        drive_step(1'b1, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        load_en = 1'b1;
        load_count = 16'd7;
        @(negedge clk);
        load_en = 1'b0;
        model_cnt = 7;
        chk_eq("load_step_count", {16'd0, count16}, 32'd7);
        chk_eq("load_step_count4", {28'd0, count4}, 32'd7);
        chk_eq("load_step_pulse", {31'd0, step16}, 32'd0);
        chk_eq("load_step_dir", {31'd0, dir16}, {31'd0, model_dir});
        repeat (10) @(negedge clk);
        chk_eq("load_hold", {16'd0, count16}, 32'd7);
        drive_step(1'b0, 1'b1);
        repeat (10) @(negedge clk);

`ifdef QDEC_INDEX_EN
        do_load(16'd5);
        idx = 1'b1;
        n = 21;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 5) idx = 1'b0;
            if (count16 == 16'd0) begin
                n = i;
                break;
            end
        end
        model_cnt = 0;
        chk_eq("index_latency", n, 32'd6);
        repeat (10) @(negedge clk);
`endif

        // inputs held at 11 through reset release: counted as 00->11, flags error
        seen0 = steps_seen;
        rstn = 1'b0;
        a = 1'b1; b = 1'b1; phase = 2;
        #1;
        chk_eq("async_rst_count", {16'd0, count16}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        model_cnt = 0;
        repeat (15) @(negedge clk);
        chk_eq("rst11_err", {31'd0, err16}, 32'd1);
        chk_eq("rst11_count", {16'd0, count16}, 32'd0);
        chk_eq("rst11_steps", steps_seen, seen0);

        chk_eq("sb_drain", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end
endmodule
